hazard3_bus_arbiter: RTL

- Shares one AHB5 manager port among N_REQ requesters that use the core-native bus handshake (aph_req / aph_ready / dph_ready / dph_err).
- Typical use: the single-port CPU top, with requester 0 = load/store, 1 = instruction fetch, 2 = debug System Bus Access.
- Fixed priority, plus an anti-starvation boost driven by per-requester wait counters.
- Tracks data-phase ownership so that write data and responses are routed to the correct requester.

---
 rtl/hazard3_bus_arbiter_pkg.sv | 22 ++
 rtl/hazard3_bus_arbiter_if.sv | 53 +++++
 rtl/hazard3_onehot_priority_sel.sv | 15 +
 rtl/hazard3_bus_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/hazard3_bus_arbiter_pkg.sv
// Shared AHB constants for the Hazard3 CPU top levels: transfer types and
// hprot bit positions.
package hazard3_bus_arbiter_pkg;

    // AHB htrans encodings. Only IDLE and NSEQ are issued; no bursts.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ   = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // hprot bit positions.
    localparam int unsigned HPROT_DATA       = 0;
    localparam int unsigned HPROT_PRIV       = 1;
    localparam int unsigned HPROT_BUFFERABLE = 2;
    localparam int unsigned HPROT_CACHEABLE  = 3;

    // Requester roles in the single-port CPU top.
    localparam int unsigned REQ_LOADSTORE = 0;
    localparam int unsigned REQ_IFETCH    = 1;
    localparam int unsigned REQ_SBA       = 2;

endpackage

// File: rtl/hazard3_bus_arbiter_if.sv
// Bundle of the requester-side core-native handshake and the AHB5 manager
// port. The arbiter uses the master modport; the environment uses slave.
interface hazard3_bus_arbiter_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32
);

    // Requester side
    logic [N_REQ-1:0]        req_aph_req;
    logic [N_REQ-1:0]        req_aph_excl;
    logic [N_REQ*W_ADDR-1:0] req_haddr;
    logic [N_REQ*3-1:0]      req_hsize;
    logic [N_REQ-1:0]        req_hwrite;
    logic [N_REQ-1:0]        req_priv;
    logic [N_REQ*W_DATA-1:0] req_wdata;
    logic [N_REQ-1:0]        req_aph_ready;
    logic [N_REQ-1:0]        req_dph_ready;
    logic [N_REQ-1:0]        req_dph_err;
    logic [N_REQ-1:0]        req_dph_exokay;
    logic [W_DATA-1:0]       req_rdata;

    // AHB manager side
    logic [W_ADDR-1:0]       haddr;
    logic                    hwrite;
    logic [1:0]              htrans;
    logic [2:0]              hsize;
    logic [3:0]              hprot;
    logic                    hexcl;
    logic [7:0]              hmaster;
    logic [W_DATA-1:0]       hwdata;
    logic                    hready;
    logic                    hresp;
    logic                    hexokay;
    logic [W_DATA-1:0]       hrdata;

    modport master (
        input  req_aph_req, req_aph_excl, req_haddr, req_hsize, req_hwrite, req_priv,
               req_wdata,
        output req_aph_ready, req_dph_ready, req_dph_err, req_dph_exokay, req_rdata,
        output haddr, hwrite, htrans, hsize, hprot, hexcl, hmaster, hwdata,
        input  hready, hresp, hexokay, hrdata
    );

    modport slave (
        output req_aph_req, req_aph_excl, req_haddr, req_hsize, req_hwrite, req_priv,
               req_wdata,
        input  req_aph_ready, req_dph_ready, req_dph_err, req_dph_exokay, req_rdata,
        input  haddr, hwrite, htrans, hsize, hprot, hexcl, hmaster, hwdata,
        output hready, hresp, hexokay, hrdata
    );

endinterface

// File: rtl/hazard3_onehot_priority_sel.sv
// Lowest-index one-hot select: gnt has at most one bit set, the lowest set
// bit of req.
module hazard3_onehot_priority_sel #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] req,
    output logic [W-1:0] gnt
);

    // Isolate the lowest set bit (two's complement trick).
    always_comb begin
        gnt = req & (~req + W'(1));
    end

endmodule

// File: rtl/hazard3_bus_arbiter.sv
// Shares one AHB5 manager port among N_REQ core-native requesters.
// Fixed priority (index 0 highest) with a wait-counter boost against
// starvation; tracks the data-phase owner to route wdata and responses.
module hazard3_bus_arbiter #(
    parameter int unsigned     N_REQ     = 3,
    parameter int unsigned     W_ADDR    = 32,
    parameter int unsigned     W_DATA    = 32,
    parameter int unsigned     MAX_WAIT  = 4,
    parameter logic [N_REQ-1:0] DATA_MASK = 3'b101
) (
    input logic                   clk,
    input logic                   rst_n,
    hazard3_bus_arbiter_if.master bus
);

    import hazard3_bus_arbiter_pkg::*;

    localparam int unsigned W_CNT = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam int unsigned W_IDX = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [W_CNT-1:0] CNT_SAT = W_CNT'(MAX_WAIT);

    logic                   hold_q;
    logic                   hold_d;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       gnt_prev_q;
    logic [N_REQ-1:0]       gnt_boost;
    logic [N_REQ-1:0]       gnt_raw;
    logic [N_REQ-1:0]       boost;
    logic [N_REQ-1:0]       dph_owner_q;
    logic [W_IDX-1:0]       gnt_idx;
    logic [W_IDX-1:0]       owner_idx;
    logic [W_CNT-1:0]       wait_cnt_q [N_REQ];
    logic [W_CNT-1:0]       wait_cnt_d [N_REQ];

    // Requesters whose wait counter has saturated jump the fixed priority.
    always_comb begin
        boost = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            boost[i] = (MAX_WAIT > 0) && bus.req_aph_req[i] && (wait_cnt_q[i] == CNT_SAT);
        end
    end

    hazard3_onehot_priority_sel #(
        .W (N_REQ)
    ) u_sel_boost (
        .req (boost),
        .gnt (gnt_boost)
    );

    hazard3_onehot_priority_sel #(
        .W (N_REQ)
    ) u_sel_req (
        .req (bus.req_aph_req),
        .gnt (gnt_raw)
    );

    // Grant: an issued-but-stalled address phase is frozen until accepted.
    always_comb begin
        if (hold_q) begin
            gnt = gnt_prev_q;
        end else if (|boost) begin
            gnt = gnt_boost;
        end else begin
            gnt = gnt_raw;
        end
    end

    // One-hot to binary for the granted requester and the data-phase owner.
    always_comb begin
        gnt_idx   = '0;
        owner_idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt[i]) begin
                gnt_idx = W_IDX'(i);
            end
            if (dph_owner_q[i]) begin
                owner_idx = W_IDX'(i);
            end
        end
    end

    // Address-phase outputs; with no grant the mux falls back to requester 0.
    always_comb begin
        bus.htrans                = (|gnt) ? HTRANS_NSEQ : HTRANS_IDLE;
        bus.haddr                 = bus.req_haddr[gnt_idx * W_ADDR +: W_ADDR];
        bus.hsize                 = bus.req_hsize[gnt_idx * 3 +: 3];
        bus.hwrite                = bus.req_hwrite[gnt_idx];
        bus.hexcl                 = bus.req_aph_excl[gnt_idx];
        bus.hmaster               = 8'(gnt_idx);
        bus.hprot                 = '0;
        bus.hprot[HPROT_DATA]     = DATA_MASK[gnt_idx];
        bus.hprot[HPROT_PRIV]     = bus.req_priv[gnt_idx];
        bus.req_aph_ready         = gnt & {N_REQ{bus.hready}};
    end

    // Data-phase routing to and from the owner of the current data phase.
    always_comb begin
        bus.hwdata = '0;
        if (|dph_owner_q) begin
            bus.hwdata = bus.req_wdata[owner_idx * W_DATA +: W_DATA];
        end
        bus.req_dph_ready  = dph_owner_q & {N_REQ{bus.hready}};
        bus.req_dph_err    = dph_owner_q & {N_REQ{bus.hresp}};
        bus.req_dph_exokay = dph_owner_q & {N_REQ{bus.hexokay}};
        bus.req_rdata      = bus.hrdata;
    end

    // Hold drops on the first error cycle so the bus can re-arbitrate then.
    always_comb begin
        hold_d = (|gnt) && !bus.hready && !bus.hresp;
    end

    // Wait counters: count lost arbitration cycles, saturate at MAX_WAIT.
    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (!bus.req_aph_req[i] || bus.req_aph_ready[i]) begin
                wait_cnt_d[i] = '0;
            end else if (bus.hready && (|gnt) && (wait_cnt_q[i] != CNT_SAT)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + W_CNT'(1);
            end
        end
    end

    // Arbitration and data-phase state; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= 1'b0;
            gnt_prev_q  <= '0;
            dph_owner_q <= '0;
            for (int i = 0; i < int'(N_REQ); i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            hold_q     <= hold_d;
            gnt_prev_q <= gnt;
            if (bus.hready) begin
                dph_owner_q <= gnt;
            end
            for (int i = 0; i < int'(N_REQ); i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

endmodule
